// File: rtl/dense_layer_sequencer.sv
// dense_layer_sequencer: fully-connected layer engine, y[j] = act(b[j] + sum_i W[j][i]*x[i]).
// It drives external float32 multiply and add cores over valid/ready handshakes and
// synchronous weight/input/bias memories, and writes each finished y[j] to the output memory.
// At most one multiply and one add are outstanding. An optional ReLU clamps results
// whose sign bit is set.
module dense_layer_sequencer #(
   parameter int IN_DIM   = 16,
   parameter int OUT_DIM  = 16,
   parameter int DATA_W   = 32,
   parameter int W_ADDR_W = (IN_DIM * OUT_DIM > 1) ? $clog2(IN_DIM * OUT_DIM) : 1,
   parameter int X_ADDR_W = (IN_DIM > 1) ? $clog2(IN_DIM) : 1,
   parameter int Y_ADDR_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                relu_en,
   output logic                busy,
   output logic                done,
   output logic [W_ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0]   w_data,
   output logic [X_ADDR_W-1:0] x_addr,
   input  logic [DATA_W-1:0]   x_data,
   output logic [Y_ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0]   b_data,
   output logic                mul_in_valid,
   input  logic                mul_in_ready,
   output logic [DATA_W-1:0]   mul_a,
   output logic [DATA_W-1:0]   mul_b,
   input  logic                mul_out_valid,
   output logic                mul_out_ready,
   input  logic [DATA_W-1:0]   mul_out_data,
   output logic                add_in_valid,
   input  logic                add_in_ready,
   output logic [DATA_W-1:0]   add_a,
   output logic [DATA_W-1:0]   add_b,
   input  logic                add_out_valid,
   output logic                add_out_ready,
   input  logic [DATA_W-1:0]   add_out_data,
   output logic                y_we,
   output logic [Y_ADDR_W-1:0] y_addr,
   output logic [DATA_W-1:0]   y_data
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_BIAS,
      S_BIAS_CAP,
      S_FETCH,
      S_CAPTURE,
      S_MUL_REQ,
      S_MUL_WAIT,
      S_ADD_REQ,
      S_ADD_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [X_ADDR_W-1:0] I_LAST   = X_ADDR_W'(IN_DIM - 1);
   localparam logic [Y_ADDR_W-1:0] J_LAST   = Y_ADDR_W'(OUT_DIM - 1);
   localparam logic [W_ADDR_W-1:0] ROW_STEP = W_ADDR_W'(IN_DIM);

   state_t              state;
   logic [X_ADDR_W-1:0] i;
   logic [Y_ADDR_W-1:0] j;
   logic [W_ADDR_W-1:0] row_base;
   logic [DATA_W-1:0]   acc;
   logic                relu_q;

   // Sequencer FSM. Every output is a register, loaded on the transition into the
   // state that presents it. mul_a/mul_b double as the captured operand registers,
   // and add_b holds the product. w_addr advances by one per MAC from a row base
   // that steps by IN_DIM per output, so no multiplier is needed and the address
   // never leaves the weight array.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         i             <= '0;
         j             <= '0;
         row_base      <= '0;
         acc           <= '0;
         relu_q        <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         w_addr        <= '0;
         x_addr        <= '0;
         b_addr        <= '0;
         mul_in_valid  <= 1'b0;
         mul_a         <= '0;
         mul_b         <= '0;
         mul_out_ready <= 1'b0;
         add_in_valid  <= 1'b0;
         add_a         <= '0;
         add_b         <= '0;
         add_out_ready <= 1'b0;
         y_we          <= 1'b0;
         y_addr        <= '0;
         y_data        <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  relu_q   <= relu_en;
                  j        <= '0;
                  row_base <= '0;
                  b_addr   <= '0;
                  busy     <= 1'b1;
                  state    <= S_BIAS;
               end
            end
            S_BIAS: begin
               state <= S_BIAS_CAP;
            end
            S_BIAS_CAP: begin
               acc    <= b_data;
               i      <= '0;
               w_addr <= row_base;
               x_addr <= '0;
               state  <= S_FETCH;
            end
            S_FETCH: begin
               state <= S_CAPTURE;
            end
            S_CAPTURE: begin
               mul_a        <= w_data;
               mul_b        <= x_data;
               mul_in_valid <= 1'b1;
               state        <= S_MUL_REQ;
            end
            S_MUL_REQ: begin
               if (mul_in_ready) begin
                  mul_in_valid  <= 1'b0;
                  mul_out_ready <= 1'b1;
                  state         <= S_MUL_WAIT;
               end
            end
            S_MUL_WAIT: begin
               if (mul_out_valid) begin
                  mul_out_ready <= 1'b0;
                  add_a         <= acc;
                  add_b         <= mul_out_data;
                  add_in_valid  <= 1'b1;
                  state         <= S_ADD_REQ;
               end
            end
            S_ADD_REQ: begin
               if (add_in_ready) begin
                  add_in_valid  <= 1'b0;
                  add_out_ready <= 1'b1;
                  state         <= S_ADD_WAIT;
               end
            end
            S_ADD_WAIT: begin
               if (add_out_valid) begin
                  acc           <= add_out_data;
                  add_out_ready <= 1'b0;
                  if (i == I_LAST) begin
                     y_we   <= 1'b1;
                     y_addr <= j;
                     y_data <= (relu_q && add_out_data[DATA_W-1]) ? '0 : add_out_data;
                     state  <= S_WRITE;
                  end else begin
                     i      <= i + X_ADDR_W'(1);
                     x_addr <= i + X_ADDR_W'(1);
                     w_addr <= w_addr + W_ADDR_W'(1);
                     state  <= S_FETCH;
                  end
               end
            end
            S_WRITE: begin
               y_we <= 1'b0;
               if (j == J_LAST) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  j        <= j + Y_ADDR_W'(1);
                  b_addr   <= j + Y_ADDR_W'(1);
                  row_base <= row_base + ROW_STEP;
                  state    <= S_BIAS;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
